dmem_responder: RTL

- Memory-side responder for the core's data-memory port. It replaces the zero-latency combinational data memory with a valid/ready request/response handshake.
- Accepts one load or store request at a time and waits a programmable number of cycles. It then returns read data or a write acknowledgement, with an error flag.
- Sits between the EX/MEM pipeline register (the initiator) and the 64-bit doubleword storage array. Lets the hazard unit stall MEM on real memory latency.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_responder.sv | 109 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder (optional DMEM_BYTE_STROBE_EN)
package dmem_pkg;

    localparam int WORD_BYTES  = 8;
    localparam int OFFSET_BITS = 3;
    localparam int REQ_ADDR_W  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic                    write;
        logic [REQ_ADDR_W-1:0]   addr;
        logic [63:0]             wdata;
        logic [WORD_BYTES-1:0]   wstrb;
    } req_t;

    // Flags misaligned addresses and any word index past the array; every
    // upper address bit takes part so high addresses never alias onto low words.
    function automatic logic addr_err(input logic [REQ_ADDR_W-1:0] addr,
                                      input int unsigned depth_words);
        logic [REQ_ADDR_W-OFFSET_BITS-1:0] index;
        index = addr[REQ_ADDR_W-1:OFFSET_BITS];
        return (addr[OFFSET_BITS-1:0] != '0) ||
               (index >= (REQ_ADDR_W-OFFSET_BITS)'(depth_words));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - doubleword storage with byte-lane write enables and combinational read
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [63:0]      i_wdata,
    input  logic [7:0]       i_wstrb,
    output logic [63:0]      o_rdata
);

    logic [63:0] r_mem [DEPTH_WORDS];

    // Byte-lane write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 8; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - valid/ready data-memory responder with programmable latency (optional DMEM_BYTE_STROBE_EN)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int ADDR_W      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [7:0]        req_wstrb,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmem_state_t r_state;
    logic [3:0]  r_cnt;
    logic [63:0] r_rsp_rdata;
    logic        r_rsp_err;

    req_t        w_req;
    logic        w_err;
    logic        w_accept;
    logic        w_we;
    logic [63:0] w_rdata;

    // Bundle the request pins; without strobes every store covers the whole word.
    always_comb begin
        w_req       = '0;
        w_req.write = req_write;
        w_req.addr  = REQ_ADDR_W'(req_addr);
        w_req.wdata = req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
        w_req.wstrb = req_wstrb;
`else
        w_req.wstrb = '1;
`endif
    end

    assign w_err    = addr_err(w_req.addr, DEPTH_WORDS);
    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_we     = w_accept && w_req.write && !w_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_idx   (w_req.addr[OFFSET_BITS +: IDX_W]),
        .i_wdata (w_req.wdata),
        .i_wstrb (w_req.wstrb),
        .o_rdata (w_rdata)
    );

    // Handshake FSM: the access happens at the accept edge, the response is
    // then held back for LATENCY-1 further edges and kept stable until taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (w_err || w_req.write) ? 64'd0 : w_rdata;
                        r_cnt       <= CNT_INIT;
                        r_state     <= (LATENCY > 1) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
